uart_rx: RTL and testbench

- Serial receiver stage that consumes the TxD line produced by the team's tx block and reconstructs parallel bytes.
- Samples RxD on a 16x-oversampled baud enable from the shared baud generator.
- Presents each received byte with a Receive-Data-Available flag.
- Reports framing and overrun errors to the SPART bus interface.

---
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx : oversampled asynchronous serial receiver (8N1 by default).
//
// The receiver synchronises RxD, finds the falling edge of the start bit,
// confirms it at mid start bit, and then samples each data bit and the stop
// bit at its centre. It publishes each completed byte with a
// Receive-Data-Available flag, a framing error flag and an overrun flag.
//
// Ports
//   clk         : system clock
//   rst         : synchronous, active-high reset
//   Enable      : single-cycle oversample tick, OVERSAMPLE ticks per bit
//   RxD         : asynchronous serial input, idles high
//   rd_ack      : consumer has read RxD_data; clears RDA and the error flags
//   RxD_data    : last received byte; the first bit received is bit 0
//   RDA         : receive data available
//   framing_err : the stop bit of the last byte was sampled low
//   overrun     : a byte completed while RDA was still set
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Enable,
    input  logic                 RxD,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] RxD_data,
    output logic                 RDA,
    output logic                 framing_err,
    output logic                 overrun
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   rda_q, rda_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;

    logic                   rx;
    logic                   done;
    logic [DATA_BITS:0]     shift_cat;

    // Two-flop synchroniser; both flops idle high so reset never looks like a start bit.
    always_comb begin
        sync1_d = RxD;
        sync2_d = sync1_q;
    end

    assign rx        = sync2_q;
    // New sample enters at the MSB so the first bit received ends up in bit 0.
    assign shift_cat = {rx, shift_q};

    // Frame-sequencing FSM: all progress happens only on Enable ticks.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        done       = 1'b0;

        if (Enable) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    // Re-check the line at mid start bit so short glitches are rejected.
                    if (tick_cnt_q == HALF_M1) begin
                        tick_cnt_d = '0;
                        if (!rx) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_q == FULL_M1) begin
                        shift_d    = shift_cat[DATA_BITS:1];
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                STOP: begin
                    // Completing at mid stop bit leaves half a bit to catch a
                    // back-to-back start edge.
                    if (tick_cnt_q == FULL_M1) begin
                        done       = 1'b1;
                        state_d    = IDLE;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output/status update; rd_ack is honoured every clk, but a completion
    // in the same cycle takes priority.
    always_comb begin
        data_d = data_q;
        rda_d  = rda_q;
        ferr_d = ferr_q;
        ovr_d  = ovr_q;

        if (done) begin
            data_d = shift_q;
            ferr_d = ~rx;
            ovr_d  = rda_q & ~rd_ack;
            rda_d  = 1'b1;
        end else if (rd_ack && rda_q) begin
            rda_d  = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            data_q     <= '0;
            rda_q      <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            data_q     <= data_d;
            rda_q      <= rda_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign RxD_data    = data_q;
    assign RDA         = rda_q;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx : self-checking bench for uart_rx. Frames are driven bit by bit
// on RxD (OVERSAMPLE Enable ticks per bit) and the outputs are compared with
// a frame-level model of the receive register and its status flags.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int OS = 16;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          Enable;
    logic          RxD;
    logic          rd_ack;
    logic [DB-1:0] RxD_data;
    logic          RDA;
    logic          framing_err;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    // Frame-level model of what the consumer should see.
    logic          m_rda;
    logic          m_ferr;
    logic          m_ovr;
    logic [DB-1:0] m_data;

    uart_rx #(
        .OVERSAMPLE(OS),
        .DATA_BITS (DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Enable     (Enable),
        .RxD        (RxD),
        .rd_ack     (rd_ack),
        .RxD_data   (RxD_data),
        .RDA        (RDA),
        .framing_err(framing_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Oversample tick: one clk in every three.
    initial begin
        Enable = 1'b0;
        forever begin
            repeat (2) @(negedge clk);
            Enable = 1'b1;
            @(negedge clk);
            Enable = 1'b0;
        end
    end

    // ---------------- model ----------------
    function automatic void model_reset();
        m_rda  = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        m_data = '0;
    endfunction

    function automatic void model_frame(input logic [DB-1:0] d, input logic stop_ok,
                                        input logic ack_same_cycle);
        m_ovr  = m_rda & ~ack_same_cycle;
        m_data = d;
        m_ferr = ~stop_ok;
        m_rda  = 1'b1;
    endfunction

    function automatic void model_ack();
        if (m_rda) begin
            m_rda  = 1'b0;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (Enable) k++;
        end
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        wait_ticks(OS);
    endtask

    task automatic send_start_data(input logic [DB-1:0] d, input int nbits);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
    endtask

    // A bad stop bit is held low only a little past its centre so the
    // receiver does not mistake the tail of it for a new start bit.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_ok);
        send_start_data(d, DB);
        if (stop_ok) begin
            send_bit(1'b1);
        end else begin
            RxD = 1'b0;
            wait_ticks(OS / 2 + 2);
            RxD = 1'b1;
            wait_ticks(OS / 2 - 2);
        end
        RxD = 1'b1;
    endtask

    task automatic do_ack();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        model_ack();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst    = 1'b1;
        RxD    = 1'b1;
        rd_ack = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            repeat (20) @(negedge clk);
            checks++;
            if ({RDA, framing_err, overrun, RxD_data} !== {m_rda, m_ferr, m_ovr, m_data}) begin
                errors++;
                $display("FAIL reset_idle[%0d] got rda=%b fe=%b ov=%b data=%h want rda=%b fe=%b ov=%b data=%h",
                         i, RDA, framing_err, overrun, RxD_data, m_rda, m_ferr, m_ovr, m_data);
            end
        end
    endtask

    task automatic test_frame_55();
        send_start_data(8'h55, DB);
        RxD = 1'b1;
        wait_ticks(4);
        checks++;
        if (RDA !== m_rda) begin
            errors++;
            $display("FAIL f55_early_rda got %b want %b", RDA, m_rda);
        end
        wait_ticks(OS - 4);
        model_frame(8'h55, 1'b1, 1'b0);
        checks++;
        if ({RDA, framing_err, overrun, RxD_data} !== {m_rda, m_ferr, m_ovr, m_data}) begin
            errors++;
            $display("FAIL f55_done got rda=%b fe=%b ov=%b data=%h want rda=%b fe=%b ov=%b data=%h",
                     RDA, framing_err, overrun, RxD_data, m_rda, m_ferr, m_ovr, m_data);
        end
        do_ack();
        checks++;
        if ({RDA, RxD_data} !== {m_rda, m_data}) begin
            errors++;
            $display("FAIL f55_ack got rda=%b data=%h want rda=%b data=%h", RDA, RxD_data, m_rda, m_data);
        end
    endtask

    task automatic test_back_to_back(input logic ack_between);
        send_frame(8'hA3, 1'b1);
        model_frame(8'hA3, 1'b1, 1'b0);
        checks++;
        if ({RDA, framing_err, RxD_data} !== {m_rda, m_ferr, m_data}) begin
            errors++;
            $display("FAIL b2b_first(ack=%b) got rda=%b fe=%b data=%h want rda=%b fe=%b data=%h",
                     ack_between, RDA, framing_err, RxD_data, m_rda, m_ferr, m_data);
        end
        if (ack_between) do_ack();
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1, 1'b0);
        checks++;
        if ({RDA, framing_err, overrun, RxD_data} !== {m_rda, m_ferr, m_ovr, m_data}) begin
            errors++;
            $display("FAIL b2b_second(ack=%b) got rda=%b fe=%b ov=%b data=%h want rda=%b fe=%b ov=%b data=%h",
                     ack_between, RDA, framing_err, overrun, RxD_data, m_rda, m_ferr, m_ovr, m_data);
        end
        do_ack();
        wait_ticks(OS);
    endtask

    task automatic test_framing();
        send_frame(8'hFF, 1'b0);
        model_frame(8'hFF, 1'b0, 1'b0);
        checks++;
        if ({RDA, framing_err, RxD_data} !== {m_rda, m_ferr, m_data}) begin
            errors++;
            $display("FAIL frame_bad_stop got rda=%b fe=%b data=%h want rda=%b fe=%b data=%h",
                     RDA, framing_err, RxD_data, m_rda, m_ferr, m_data);
        end
        wait_ticks(2 * OS);
        do_ack();
        send_frame(8'h0F, 1'b1);
        model_frame(8'h0F, 1'b1, 1'b0);
        checks++;
        if ({RDA, framing_err, overrun, RxD_data} !== {m_rda, m_ferr, m_ovr, m_data}) begin
            errors++;
            $display("FAIL frame_recover got rda=%b fe=%b ov=%b data=%h want rda=%b fe=%b ov=%b data=%h",
                     RDA, framing_err, overrun, RxD_data, m_rda, m_ferr, m_ovr, m_data);
        end
    endtask

    task automatic test_glitch();
        do_ack();
        RxD = 1'b0;
        wait_ticks(5);
        RxD = 1'b1;
        wait_ticks(2 * OS);
        checks++;
        if ({RDA, RxD_data} !== {m_rda, m_data}) begin
            errors++;
            $display("FAIL glitch_reject got rda=%b data=%h want rda=%b data=%h", RDA, RxD_data, m_rda, m_data);
        end
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1, 1'b0);
        checks++;
        if ({RDA, framing_err, overrun, RxD_data} !== {m_rda, m_ferr, m_ovr, m_data}) begin
            errors++;
            $display("FAIL glitch_then_81 got rda=%b fe=%b ov=%b data=%h want rda=%b fe=%b ov=%b data=%h",
                     RDA, framing_err, overrun, RxD_data, m_rda, m_ferr, m_ovr, m_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        // RDA is still set from the previous frame, so the reset is visible.
        send_start_data(8'hC6, 4);
        rst = 1'b1;
        RxD = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if ({RDA, framing_err, overrun, RxD_data} !== {m_rda, m_ferr, m_ovr, m_data}) begin
            errors++;
            $display("FAIL reset_mid got rda=%b fe=%b ov=%b data=%h want all zero",
                     RDA, framing_err, overrun, RxD_data);
        end
        wait_ticks(2 * OS);
        send_frame(8'h42, 1'b1);
        model_frame(8'h42, 1'b1, 1'b0);
        checks++;
        if ({RDA, framing_err, overrun, RxD_data} !== {m_rda, m_ferr, m_ovr, m_data}) begin
            errors++;
            $display("FAIL after_reset_42 got rda=%b fe=%b ov=%b data=%h want rda=%b fe=%b ov=%b data=%h",
                     RDA, framing_err, overrun, RxD_data, m_rda, m_ferr, m_ovr, m_data);
        end
    endtask

    // rd_ack is held through the stop bit and dropped the clk RDA is seen
    // set, so it is high in the completion cycle itself.
    task automatic test_ack_coincident();
        logic [DB-1:0] b;
        int            budget;
        logic          seen;
        b = DB'($urandom);
        send_start_data(b, DB);
        RxD    = 1'b1;
        rd_ack = 1'b1;
        model_ack();
        seen   = 1'b0;
        budget = 3 * OS * 3;
        @(negedge clk);
        while (!seen && budget > 0) begin
            @(negedge clk);
            budget--;
            if (RDA === 1'b1) seen = 1'b1;
        end
        rd_ack = 1'b0;
        model_frame(b, 1'b1, 1'b1);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ack_coincident_timeout RDA never rose while rd_ack held, got rda=%b want 1", RDA);
        end else if ({RDA, framing_err, overrun, RxD_data} !== {m_rda, m_ferr, m_ovr, m_data}) begin
            errors++;
            $display("FAIL ack_coincident got rda=%b fe=%b ov=%b data=%h want rda=%b fe=%b ov=%b data=%h",
                     RDA, framing_err, overrun, RxD_data, m_rda, m_ferr, m_ovr, m_data);
        end
        wait_ticks(OS);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            logic [DB-1:0] b;
            logic          stop_ok;
            b       = DB'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) do_ack();
            send_frame(b, stop_ok);
            model_frame(b, stop_ok, 1'b0);
            checks++;
            if ({RDA, framing_err, overrun, RxD_data} !== {m_rda, m_ferr, m_ovr, m_data}) begin
                errors++;
                $display("FAIL random[%0d] got rda=%b fe=%b ov=%b data=%h want rda=%b fe=%b ov=%b data=%h",
                         i, RDA, framing_err, overrun, RxD_data, m_rda, m_ferr, m_ovr, m_data);
            end
            if (!stop_ok) wait_ticks(2 * OS);
            else wait_ticks($urandom_range(0, 3));
        end
    endtask

    initial begin
        rst    = 1'b1;
        RxD    = 1'b1;
        rd_ack = 1'b0;
        model_reset();
        test_reset();
        test_frame_55();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_framing();
        test_glitch();
        test_reset_mid_frame();
        test_ack_coincident();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
